// File: rtl/bp_dma_axil_ctrl.sv
// bp_dma_axil_ctrl: turns bsg_cache DMA packets into a block of single-beat
// AXI4-Lite transactions on consecutive data-word addresses, keeping exactly
// one AXI transaction outstanding and latching any error responses.
module bp_dma_axil_ctrl #(
  parameter int daddr_width_p         = 28,
  parameter int axil_addr_width_p     = 28,
  parameter int data_width_p          = 64,
  parameter int block_size_in_words_p = 8
) (
  input  logic                          clk_i,
  input  logic                          reset_i,

  input  logic [daddr_width_p:0]        dma_pkt_i,
  input  logic                          dma_pkt_v_i,
  output logic                          dma_pkt_yumi_o,

  output logic [data_width_p-1:0]       dma_data_o,
  output logic                          dma_data_v_o,
  input  logic                          dma_data_ready_and_i,

  input  logic [data_width_p-1:0]       dma_data_i,
  input  logic                          dma_data_v_i,
  output logic                          dma_data_yumi_o,

  output logic [axil_addr_width_p-1:0]  araddr_o,
  output logic [2:0]                    arprot_o,
  output logic                          arvalid_o,
  input  logic                          arready_i,
  input  logic [data_width_p-1:0]       rdata_i,
  input  logic [1:0]                    rresp_i,
  input  logic                          rvalid_i,
  output logic                          rready_o,

  output logic [axil_addr_width_p-1:0]  awaddr_o,
  output logic [2:0]                    awprot_o,
  output logic                          awvalid_o,
  input  logic                          awready_i,
  output logic [data_width_p-1:0]       wdata_o,
  output logic [data_width_p/8-1:0]     wstrb_o,
  output logic                          wvalid_o,
  input  logic                          wready_i,
  input  logic [1:0]                    bresp_i,
  input  logic                          bvalid_i,
  output logic                          bready_o,

  output logic                          rd_error_o,
  output logic                          wr_error_o,
  output logic                          busy_o
);

  localparam int Bytes = data_width_p / 8;
  localparam int OffW  = $clog2(block_size_in_words_p * Bytes);
  localparam int CntW  = $clog2(block_size_in_words_p);
  localparam logic [daddr_width_p-1:0] OffMask = daddr_width_p'((1 << OffW) - 1);
  localparam logic [CntW-1:0] LastCnt = CntW'(block_size_in_words_p - 1);

  typedef enum logic [2:0] {
    IDLE,
    RD_ADDR,
    RD_DATA,
    WR_REQ,
    WR_RESP
  } state_e;

  state_e                   r_state;
  logic [daddr_width_p-1:0] r_base;
  logic [CntW-1:0]          r_cnt;
  logic                     r_aw_done;
  logic                     r_w_done;
  logic                     r_rd_error;
  logic                     r_wr_error;

  logic [daddr_width_p-1:0] w_offset;
  logic [daddr_width_p-1:0] w_beat_addr;
  logic                     w_last;
  logic                     w_aw_fire;
  logic                     w_w_fire;
  logic                     w_wr_both;
  logic                     w_rd_fire;

  // Beat address and handshake qualifiers shared by the FSM and the outputs
  always_comb begin
    w_offset    = daddr_width_p'(r_cnt) << $clog2(Bytes);
    w_beat_addr = r_base + w_offset;
    w_last      = (r_cnt == LastCnt);
    w_aw_fire   = awvalid_o & awready_i;
    w_w_fire    = wvalid_o & wready_i;
    w_wr_both   = (r_aw_done | w_aw_fire) & (r_w_done | w_w_fire);
    w_rd_fire   = (r_state == RD_DATA) & rvalid_i & dma_data_ready_and_i;
  end

  // Output decode: valids come only from registered state and the cache's
  // data valid, never from the slave's ready signals
  always_comb begin
    dma_pkt_yumi_o  = (r_state == IDLE) & dma_pkt_v_i;
    dma_data_o      = rdata_i;
    dma_data_v_o    = (r_state == RD_DATA) & rvalid_i;
    rready_o        = (r_state == RD_DATA) & dma_data_ready_and_i;
    araddr_o        = w_beat_addr[axil_addr_width_p-1:0];
    arprot_o        = 3'b000;
    arvalid_o       = (r_state == RD_ADDR);
    awaddr_o        = w_beat_addr[axil_addr_width_p-1:0];
    awprot_o        = 3'b000;
    awvalid_o       = (r_state == WR_REQ) & dma_data_v_i & ~r_aw_done;
    wdata_o         = dma_data_i;
    wstrb_o         = '1;
    wvalid_o        = (r_state == WR_REQ) & dma_data_v_i & ~r_w_done;
    dma_data_yumi_o = (r_state == WR_REQ) & w_wr_both;
    bready_o        = (r_state == WR_RESP);
    rd_error_o      = r_rd_error;
    wr_error_o      = r_wr_error;
    busy_o          = (r_state != IDLE);
  end

  // Packet sequencer: one AXI transaction in flight, counter steps per beat
  always_ff @(posedge clk_i) begin
    if (reset_i) begin
      r_state    <= IDLE;
      r_base     <= '0;
      r_cnt      <= '0;
      r_aw_done  <= 1'b0;
      r_w_done   <= 1'b0;
      r_rd_error <= 1'b0;
      r_wr_error <= 1'b0;
    end else begin
      case (r_state)
        IDLE: begin
          if (dma_pkt_v_i) begin
            r_base  <= dma_pkt_i[daddr_width_p-1:0] & ~OffMask;
            r_cnt   <= '0;
            r_state <= dma_pkt_i[daddr_width_p] ? WR_REQ : RD_ADDR;
          end
        end
        RD_ADDR: begin
          if (arready_i) r_state <= RD_DATA;
        end
        RD_DATA: begin
          if (w_rd_fire) begin
            if (rresp_i != 2'b00) r_rd_error <= 1'b1;
            r_cnt   <= r_cnt + 1'b1;
            r_state <= w_last ? IDLE : RD_ADDR;
          end
        end
        WR_REQ: begin
          if (w_wr_both) begin
            r_aw_done <= 1'b0;
            r_w_done  <= 1'b0;
            r_state   <= WR_RESP;
          end else begin
            if (w_aw_fire) r_aw_done <= 1'b1;
            if (w_w_fire)  r_w_done  <= 1'b1;
          end
        end
        WR_RESP: begin
          if (bvalid_i) begin
            if (bresp_i != 2'b00) r_wr_error <= 1'b1;
            r_cnt   <= r_cnt + 1'b1;
            r_state <= w_last ? IDLE : WR_REQ;
          end
        end
        default: r_state <= IDLE;
      endcase
    end
  end

endmodule
